jtframe_sdram_romctl: RTL



---
 rtl/jtframe_sdram_cmd.sv | 28 ++
 rtl/jtframe_sdram_rfsh.sv | 37 +++
 rtl/jtframe_sdram_romctl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_sdram_cmd.sv
// Shared SDRAM command encodings and mode-register builder.
// {ncs,nras,ncas,nwe} ordering on every command constant.
package jtframe_sdram_cmd;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    localparam int BURST_LEN = 2;

    // Single-write mode, sequential burst, CAS latency and burst length.
    function automatic logic [12:0] mode_reg(input int cl, input int bl);
        logic [2:0] bl_code;
        if (bl == 1)
            bl_code = 3'd0;
        else if (bl == 2)
            bl_code = 3'd1;
        else if (bl == 4)
            bl_code = 3'd2;
        else
            bl_code = 3'd3;
        return {3'b000, 1'b1, 2'b00, 3'(cl), 1'b0, bl_code};
    endfunction

endpackage

// File: rtl/jtframe_sdram_rfsh.sv
// Auto-refresh interval timer with a sticky pending flag.
// An expiry while already pending merges into one refresh.
module jtframe_sdram_rfsh #(
    parameter int PERIOD = 750
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ack,
    output logic pending
);

    localparam int CW = $clog2(PERIOD + 1);

    logic [CW-1:0] cnt;
    logic          pend_q;
    logic          expire;

    assign expire  = en && (cnt == '0);
    // Expiry is visible in the same cycle so IDLE can favour it.
    assign pending = pend_q | expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= CW'(PERIOD - 1);
            pend_q <= 1'b0;
        end else begin
            if (en)
                cnt <= expire ? CW'(PERIOD - 1) : cnt - CW'(1);
            if (ack)
                pend_q <= 1'b0;
            else if (expire)
                pend_q <= 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_sdram_romctl.sv
// Read-only SDRAM controller: init, auto-refresh, ACT + READ/AP burst-of-2.
// All pin outputs are registered; one wait counter serves every state.
module jtframe_sdram_romctl
    import jtframe_sdram_cmd::*;
#(
    parameter int         SDRAMW      = 22,
    parameter logic [1:0] BANK        = 2'd0,
    parameter int         CL          = 2,
    parameter int         T_INIT      = 10000,
    parameter int         T_RCD       = 2,
    parameter int         T_RP        = 2,
    parameter int         T_RFC       = 8,
    parameter int         RFSH_PERIOD = 750
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdram_req,
    input  logic [SDRAMW-1:0] sdram_addr,
    output logic              sdram_ack,
    output logic              data_dst,
    output logic              data_rdy,
    output logic [15:0]       data_read,
    output logic              init_done,
    input  logic [15:0]       sdram_dq,
    output logic [12:0]       sdram_a,
    output logic [1:0]        sdram_ba,
    output logic              sdram_ncs,
    output logic              sdram_nras,
    output logic              sdram_ncas,
    output logic              sdram_nwe,
    output logic              sdram_dqml,
    output logic              sdram_dqmh,
    output logic              sdram_cke
);

    localparam int WW = $clog2(T_INIT + T_RFC + T_RP + T_RCD + CL + 8);
    // Extra precharge wait beyond the data phase, if auto-precharge needs it.
    localparam int RP_EXTRA = (T_RP > CL + 1) ? (T_RP - CL - 1) : 0;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF,
        ST_INIT_MRS,
        ST_IDLE,
        ST_ACT,
        ST_RCD,
        ST_READ,
        ST_DATA,
        ST_RP,
        ST_REF
    } state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic [2:0]    ref_left;
    logic [8:0]    col;
    logic [3:0]    cmd;
    logic          dqm;
    logic          rfsh_pending;
    logic          rfsh_ack;

    assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd;
    assign sdram_ba   = BANK;
    assign sdram_dqml = dqm;
    assign sdram_dqmh = dqm;
    assign sdram_cke  = 1'b1;
    assign rfsh_ack   = (state == ST_IDLE) && rfsh_pending;

    jtframe_sdram_rfsh #(
        .PERIOD (RFSH_PERIOD)
    ) u_rfsh (
        .clk     (clk),
        .rst     (rst),
        .en      (init_done),
        .ack     (rfsh_ack),
        .pending (rfsh_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT_WAIT;
            wcnt      <= WW'(T_INIT - 1);
            ref_left  <= 3'd0;
            col       <= 9'd0;
            cmd       <= CMD_NOP;
            sdram_a   <= 13'd0;
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            init_done <= 1'b0;
            dqm       <= 1'b1;
            data_read <= 16'd0;
        end else begin
            cmd       <= CMD_NOP;
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= sdram_dq;
            unique case (state)
                ST_INIT_WAIT: begin
                    if (wcnt == '0) begin
                        cmd     <= CMD_PRE;
                        sdram_a <= 13'h0400;
                        wcnt    <= WW'(T_RP - 1);
                        state   <= ST_INIT_PRE;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                ST_INIT_PRE: begin
                    if (wcnt == '0) begin
                        cmd      <= CMD_REF;
                        sdram_a  <= 13'd0;
                        wcnt     <= WW'(T_RFC - 1);
                        ref_left <= 3'd7;
                        state    <= ST_INIT_REF;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                ST_INIT_REF: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - WW'(1);
                    end else if (ref_left == 3'd0) begin
                        cmd     <= CMD_MRS;
                        sdram_a <= mode_reg(CL, BURST_LEN);
                        wcnt    <= WW'(1);
                        state   <= ST_INIT_MRS;
                    end else begin
                        cmd      <= CMD_REF;
                        ref_left <= ref_left - 3'd1;
                        wcnt     <= WW'(T_RFC - 1);
                    end
                end
                ST_INIT_MRS: begin
                    if (wcnt == '0) begin
                        init_done <= 1'b1;
                        dqm       <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                ST_IDLE: begin
                    if (rfsh_pending) begin
                        cmd   <= CMD_REF;
                        wcnt  <= WW'(T_RFC - 1);
                        state <= ST_REF;
                    end else if (sdram_req) begin
                        cmd       <= CMD_ACT;
                        sdram_a   <= 13'(sdram_addr[SDRAMW-1:9]);
                        col       <= sdram_addr[8:0];
                        sdram_ack <= 1'b1;
                        state     <= ST_ACT;
                    end
                end
                ST_ACT: begin
                    wcnt  <= WW'(T_RCD - 2);
                    state <= ST_RCD;
                end
                ST_RCD: begin
                    if (wcnt == '0) begin
                        cmd     <= CMD_READ;
                        sdram_a <= {2'b00, 1'b1, 1'b0, col};
                        state   <= ST_READ;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                ST_READ: begin
                    wcnt  <= '0;
                    state <= ST_DATA;
                end
                ST_DATA: begin
                    wcnt <= wcnt + WW'(1);
                    if (wcnt == WW'(CL - 1))
                        data_dst <= 1'b1;
                    if (wcnt == WW'(CL))
                        data_rdy <= 1'b1;
                    if (wcnt == WW'(CL + 1)) begin
                        if (RP_EXTRA > 0) begin
                            wcnt  <= WW'(RP_EXTRA - 1);
                            state <= ST_RP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RP, ST_REF: begin
                    if (wcnt == '0)
                        state <= ST_IDLE;
                    else
                        wcnt <= wcnt - WW'(1);
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule
